// File: rtl/vc_flit_buffer_pkg.sv
// rtl/vc_flit_buffer_pkg.sv - shared router buffer constants and width helpers
package vc_flit_buffer_pkg;

    localparam int FLIT_SIZE_DEFAULT = 82;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/vc_fifo_ctrl.sv
// rtl/vc_fifo_ctrl.sv - head/tail/count bookkeeping and flags for one VC queue
module vc_fifo_ctrl #(
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6,
    parameter int PTR_W        = 3,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             wr_ok,
    output logic             rd_ok,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags come from the registered count only, so a full queue never passes a write through.
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(AFULL_THRESH));

    assign wr_ok = wr_req && !full && !rst;
    assign rd_ok = rd_req && !empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) tail <= wrap_inc(tail);
            if (rd_ok) head <= wrap_inc(head);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_flit_buffer.sv
// rtl/vc_flit_buffer.sv - multi-VC FWFT input flit buffer; VCBUF_ERR_STICKY_EN adds sticky ovf/udf flags
module vc_flit_buffer
    import vc_flit_buffer_pkg::*;
#(
    parameter int FLIT_SIZE    = FLIT_SIZE_DEFAULT,
    parameter int NUM_VC       = 2,
    parameter int VC_DEPTH     = 8,
    parameter int AFULL_THRESH = 6,
    parameter int VC_W         = max1(clog2(NUM_VC)),
    parameter int PTR_W        = max1(clog2(VC_DEPTH)),
    parameter int CNT_W        = clog2(VC_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_SIZE-1:0]        in_flit,
    input  logic [VC_W-1:0]             in_vc,
    input  logic                        produce,
    input  logic                        consume,
    input  logic [VC_W-1:0]             consume_vc,
    output logic [NUM_VC*FLIT_SIZE-1:0] out_flit,
    output logic [NUM_VC-1:0]           empty,
    output logic [NUM_VC-1:0]           full,
    output logic [NUM_VC-1:0]           almost_full,
    output logic [NUM_VC*CNT_W-1:0]     usedw
`ifdef VCBUF_ERR_STICKY_EN
    ,
    output logic [NUM_VC-1:0]           ovf_err,
    output logic [NUM_VC-1:0]           udf_err
`endif
);

    logic [NUM_VC-1:0] wr_req;
    logic [NUM_VC-1:0] rd_req;
    logic [NUM_VC-1:0] wr_ok;
    logic [NUM_VC-1:0] rd_ok;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [FLIT_SIZE-1:0] mem [VC_DEPTH];
        logic [PTR_W-1:0]     head;
        logic [PTR_W-1:0]     tail;
        logic [CNT_W-1:0]     count;

        // Select values at or above NUM_VC match no queue and are dropped.
        assign wr_req[v] = produce && (in_vc == VC_W'(v));
        assign rd_req[v] = consume && (consume_vc == VC_W'(v));

        vc_fifo_ctrl #(
            .DEPTH        (VC_DEPTH),
            .AFULL_THRESH (AFULL_THRESH),
            .PTR_W        (PTR_W),
            .CNT_W        (CNT_W)
        ) u_ctrl (
            .clk         (clk),
            .rst         (rst),
            .wr_req      (wr_req[v]),
            .rd_req      (rd_req[v]),
            .wr_ok       (wr_ok[v]),
            .rd_ok       (rd_ok[v]),
            .head        (head),
            .tail        (tail),
            .count       (count),
            .empty       (empty[v]),
            .full        (full[v]),
            .almost_full (almost_full[v])
        );

        always_ff @(posedge clk) begin
            if (wr_ok[v]) mem[tail] <= in_flit;
        end

        assign out_flit[v*FLIT_SIZE +: FLIT_SIZE] = empty[v] ? '0 : mem[head];
        assign usedw[v*CNT_W +: CNT_W]            = count;
    end

`ifdef VCBUF_ERR_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= '0;
            udf_err <= '0;
        end else begin
            ovf_err <= ovf_err | (wr_req & full);
            udf_err <= udf_err | (rd_req & empty);
        end
    end
`endif

endmodule

// File: tb/tb_vc_flit_buffer.sv
// tb/tb_vc_flit_buffer.sv - directed table-driven bench for vc_flit_buffer (NUM_VC=2, VC_DEPTH=5)
module tb_vc_flit_buffer;

    localparam int FS = 82;
    localparam int NV = 2;
    localparam int CW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [FS-1:0]    in_flit;
    logic             in_vc;
    logic             produce;
    logic             consume;
    logic             consume_vc;
    logic [NV*FS-1:0] out_flit;
    logic [NV-1:0]    empty;
    logic [NV-1:0]    full;
    logic [NV-1:0]    almost_full;
    logic [NV*CW-1:0] usedw;
`ifdef VCBUF_ERR_STICKY_EN
    logic [NV-1:0]    ovf_err;
    logic [NV-1:0]    udf_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vc_flit_buffer #(
        .FLIT_SIZE    (FS),
        .NUM_VC       (NV),
        .VC_DEPTH     (5),
        .AFULL_THRESH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_vc       (in_vc),
        .produce     (produce),
        .consume     (consume),
        .consume_vc  (consume_vc),
        .out_flit    (out_flit),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .usedw       (usedw)
`ifdef VCBUF_ERR_STICKY_EN
        ,
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
`endif
    );

    typedef struct {
        logic          p;
        logic          ivc;
        logic          c;
        logic          cvc;
        logic [FS-1:0] flit;
        logic [CW-1:0] u0;
        logic [CW-1:0] u1;
        logic [1:0]    emp;
        logic [1:0]    ful;
        logic [1:0]    af;
        logic [FS-1:0] h0;
        logic [FS-1:0] h1;
        logic [1:0]    ovf;
        logic [1:0]    udf;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic p, ivc, c, cvc, input logic [FS-1:0] flit,
                                input logic [CW-1:0] u0, u1, input logic [1:0] emp, ful, af,
                                input logic [FS-1:0] h0, h1, input logic [1:0] ovf, udf);
        vec_t r;
        r.p = p; r.ivc = ivc; r.c = c; r.cvc = cvc; r.flit = flit;
        r.u0 = u0; r.u1 = u1; r.emp = emp; r.ful = ful; r.af = af;
        r.h0 = h0; r.h1 = h1; r.ovf = ovf; r.udf = udf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [FS-1:0] act, input logic [FS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FS-1:0] head_of(input int v);
        return out_flit[v*FS +: FS];
    endfunction

    function automatic logic [CW-1:0] used_of(input int v);
        return usedw[v*CW +: CW];
    endfunction

    task automatic step(input logic p, input logic ivc, input logic c, input logic cvc,
                        input logic [FS-1:0] flit);
        produce = p; in_vc = ivc; consume = c; consume_vc = cvc; in_flit = flit;
        @(posedge clk);
        #1;
        produce = 1'b0; consume = 1'b0; in_flit = '0;
    endtask

    initial begin
        // fill/drain VC1, empty pop, then cross-VC write+pop
        vecs[0]  = mk(1,1,0,0, 82'h1, 0,1, 2'b01,2'b00,2'b00, 82'h0,82'h1, 2'b00,2'b00);
        vecs[1]  = mk(1,1,0,0, 82'h2, 0,2, 2'b01,2'b00,2'b00, 82'h0,82'h1, 2'b00,2'b00);
        vecs[2]  = mk(1,1,0,0, 82'h3, 0,3, 2'b01,2'b00,2'b00, 82'h0,82'h1, 2'b00,2'b00);
        vecs[3]  = mk(1,1,0,0, 82'h4, 0,4, 2'b01,2'b00,2'b10, 82'h0,82'h1, 2'b00,2'b00);
        vecs[4]  = mk(1,1,0,0, 82'h5, 0,5, 2'b01,2'b10,2'b10, 82'h0,82'h1, 2'b00,2'b00);
        vecs[5]  = mk(1,1,0,0, 82'h6, 0,5, 2'b01,2'b10,2'b10, 82'h0,82'h1, 2'b10,2'b00);
        vecs[6]  = mk(0,0,1,1, 82'h0, 0,4, 2'b01,2'b00,2'b10, 82'h0,82'h2, 2'b10,2'b00);
        vecs[7]  = mk(0,0,1,1, 82'h0, 0,3, 2'b01,2'b00,2'b00, 82'h0,82'h3, 2'b10,2'b00);
        vecs[8]  = mk(0,0,1,1, 82'h0, 0,2, 2'b01,2'b00,2'b00, 82'h0,82'h4, 2'b10,2'b00);
        vecs[9]  = mk(0,0,1,1, 82'h0, 0,1, 2'b01,2'b00,2'b00, 82'h0,82'h5, 2'b10,2'b00);
        vecs[10] = mk(0,0,1,1, 82'h0, 0,0, 2'b11,2'b00,2'b00, 82'h0,82'h0, 2'b10,2'b00);
        vecs[11] = mk(0,0,1,1, 82'h0, 0,0, 2'b11,2'b00,2'b00, 82'h0,82'h0, 2'b10,2'b10);
        vecs[12] = mk(1,1,0,0, 82'hA, 0,1, 2'b01,2'b00,2'b00, 82'h0,82'hA, 2'b10,2'b10);
        vecs[13] = mk(1,1,0,0, 82'hC, 0,2, 2'b01,2'b00,2'b00, 82'h0,82'hA, 2'b10,2'b10);
        vecs[14] = mk(1,0,1,1, 82'hB, 1,1, 2'b00,2'b00,2'b00, 82'hB,82'hC, 2'b10,2'b10);
        vecs[15] = mk(0,0,1,0, 82'h0, 0,1, 2'b01,2'b00,2'b00, 82'h0,82'hC, 2'b10,2'b10);
        vecs[16] = mk(0,0,1,1, 82'h0, 0,0, 2'b11,2'b00,2'b00, 82'h0,82'h0, 2'b10,2'b10);

        rst = 1'b1; produce = 1'b0; consume = 1'b0; in_vc = 1'b0; consume_vc = 1'b0; in_flit = '0;
        @(posedge clk);
        #1;
        chk("reset_usedw", FS'(usedw), '0);
        chk("reset_empty", FS'(empty), FS'(2'b11));
        chk("reset_full", FS'(full), '0);
        chk("reset_afull", FS'(almost_full), '0);
        chk("reset_out_flit0", head_of(0), '0);
        chk("reset_out_flit1", head_of(1), '0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].p, vecs[i].ivc, vecs[i].c, vecs[i].cvc, vecs[i].flit);
            chk($sformatf("vec%0d_usedw0", i), FS'(used_of(0)), FS'(vecs[i].u0));
            chk($sformatf("vec%0d_usedw1", i), FS'(used_of(1)), FS'(vecs[i].u1));
            chk($sformatf("vec%0d_empty", i), FS'(empty), FS'(vecs[i].emp));
            chk($sformatf("vec%0d_full", i), FS'(full), FS'(vecs[i].ful));
            chk($sformatf("vec%0d_afull", i), FS'(almost_full), FS'(vecs[i].af));
            chk($sformatf("vec%0d_head0", i), head_of(0), vecs[i].h0);
            chk($sformatf("vec%0d_head1", i), head_of(1), vecs[i].h1);
`ifdef VCBUF_ERR_STICKY_EN
            chk($sformatf("vec%0d_ovf", i), FS'(ovf_err), FS'(vecs[i].ovf));
            chk($sformatf("vec%0d_udf", i), FS'(udf_err), FS'(vecs[i].udf));
`endif
        end

        // wrap-around: 12 write/pop pairs on VC0
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, FS'(32'h100 + i));
            chk($sformatf("wrap%0d_head", i), head_of(0), FS'(32'h100 + i));
            chk($sformatf("wrap%0d_used1", i), FS'(used_of(0)), FS'(1));
            step(1'b0, 1'b0, 1'b1, 1'b0, '0);
            chk($sformatf("wrap%0d_used0", i), FS'(used_of(0)), FS'(0));
        end

        // full VC0 + produce + consume: pop wins, write dropped
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, FS'(32'h21 + i));
        chk("fill_full0", FS'(full[0]), FS'(1));
        chk("fill_used0", FS'(used_of(0)), FS'(5));
        step(1'b1, 1'b0, 1'b1, 1'b0, FS'(32'h26));
        chk("simfull_used0", FS'(used_of(0)), FS'(4));
        chk("simfull_head0", head_of(0), FS'(32'h22));
        chk("simfull_full0", FS'(full[0]), FS'(0));
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d_head", j), head_of(0), FS'(32'h22 + j));
            step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
        chk("drain_empty0", FS'(empty[0]), FS'(1));
        chk("drain_head0", head_of(0), '0);

        // empty VC0 + produce + consume: write accepted, pop ignored
        step(1'b1, 1'b0, 1'b1, 1'b0, FS'(32'h77));
        chk("simempty_used0", FS'(used_of(0)), FS'(1));
        chk("simempty_head0", head_of(0), FS'(32'h77));

        // reset mid-stream with 3 flits held and a produce in the reset cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, FS'(32'h78));
        step(1'b1, 1'b0, 1'b0, 1'b0, FS'(32'h79));
        chk("prerst_used0", FS'(used_of(0)), FS'(3));
`ifdef VCBUF_ERR_STICKY_EN
        chk("prerst_ovf", FS'(ovf_err), FS'(2'b11));
`endif
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, FS'(32'h99));
        chk("midrst_usedw", FS'(usedw), '0);
        chk("midrst_empty", FS'(empty), FS'(2'b11));
        chk("midrst_out_flit", FS'(out_flit[FS-1:0] | out_flit[2*FS-1:FS]), '0);
`ifdef VCBUF_ERR_STICKY_EN
        chk("midrst_ovf", FS'(ovf_err), '0);
        chk("midrst_udf", FS'(udf_err), '0);
`endif
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, FS'(32'h55));
        chk("postrst_head1", head_of(1), FS'(32'h55));
        chk("postrst_used1", FS'(used_of(1)), FS'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
